// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source encoding for the common-data-bus arbiter.
package cdb_arbiter_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_ADDR_W = 32;
  localparam int CDB_NICK_W = 4;
  localparam int CDB_DEPTH  = 2;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

endpackage

// File: rtl/cdb_fifo.sv
// Small result FIFO feeding the CDB arbiter; power-of-two depth so the
// pointers wrap by natural overflow, count carries one extra bit for full.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = CDB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset; count alone says what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail_ptr] <= push_data;
  end

  assign head = mem[head_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter between buffered ALU and LSB results, broadcasting
// one registered CDB beat per cycle to RS, SLB and ROB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W = CDB_DATA_W,
  parameter int ADDR_W = CDB_ADDR_W,
  parameter int NICK_W = CDB_NICK_W,
  parameter int DEPTH  = CDB_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              iROB_clr,
  input  logic              iALU_en,
  input  logic [NICK_W-1:0] iALU_nick,
  input  logic [DATA_W-1:0] iALU_dt,
  input  logic              iALU_isBJ,
  input  logic [ADDR_W-1:0] iALU_j_pc,
  output logic              oALU_rdy,
  input  logic              iLSB_en,
  input  logic [NICK_W-1:0] iLSB_nick,
  input  logic [DATA_W-1:0] iLSB_dt,
  output logic              oLSB_rdy,
  output logic              oCDB_en,
  output logic [NICK_W-1:0] oCDB_nick,
  output logic [DATA_W-1:0] oCDB_dt,
  output logic              oCDB_isBJ,
  output logic [ADDR_W-1:0] oCDB_j_pc,
  output logic              oCDB_src
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = NICK_W + DATA_W + 1 + ADDR_W;
  localparam int LW = NICK_W + DATA_W;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic          alive;
  logic          act;
  logic          flush;
  logic          alu_push;
  logic          lsb_push;
  logic          alu_pop;
  logic          lsb_pop;
  logic          alu_ne;
  logic          lsb_ne;
  logic          grant_alu;
  logic          grant_lsb;
  logic [CW-1:0] alu_cnt;
  logic [CW-1:0] lsb_cnt;
  logic [AW-1:0] alu_head;
  logic [LW-1:0] lsb_head;
  cdb_src_e      last_grant;

  assign act   = rdy && !iROB_clr;
  assign flush = rdy && iROB_clr;

  // Readiness looks only at registered counts, so a pop this cycle never
  // frees a slot combinationally back to RS issue.
  assign oALU_rdy = alive && act && (alu_cnt != CNT_FULL);
  assign oLSB_rdy = alive && act && (lsb_cnt != CNT_FULL);
  assign alu_push = iALU_en && oALU_rdy;
  assign lsb_push = iLSB_en && oLSB_rdy;

  assign alu_ne    = alu_cnt != '0;
  assign lsb_ne    = lsb_cnt != '0;
  assign grant_alu = alu_ne && (!lsb_ne || last_grant == CDB_SRC_LSB);
  assign grant_lsb = lsb_ne && !grant_alu;
  assign alu_pop   = act && grant_alu;
  assign lsb_pop   = act && grant_lsb;

  cdb_fifo #(.W(AW), .DEPTH(DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_push),
    .pop       (alu_pop),
    .flush     (flush),
    .push_data ({iALU_nick, iALU_dt, iALU_isBJ, iALU_j_pc}),
    .count     (alu_cnt),
    .head      (alu_head)
  );

  cdb_fifo #(.W(LW), .DEPTH(DEPTH)) u_lsb_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lsb_push),
    .pop       (lsb_pop),
    .flush     (flush),
    .push_data ({iLSB_nick, iLSB_dt}),
    .count     (lsb_cnt),
    .head      (lsb_head)
  );

  // Holds both rdy outputs low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oCDB_en    <= 1'b0;
      oCDB_nick  <= '0;
      oCDB_dt    <= '0;
      oCDB_isBJ  <= 1'b0;
      oCDB_j_pc  <= '0;
      oCDB_src   <= CDB_SRC_ALU;
      last_grant <= CDB_SRC_LSB;
    end else if (flush) begin
      oCDB_en    <= 1'b0;
      last_grant <= CDB_SRC_LSB;
    end else if (act) begin
      oCDB_en <= grant_alu || grant_lsb;
      if (alu_ne && lsb_ne) last_grant <= grant_alu ? CDB_SRC_ALU : CDB_SRC_LSB;
      if (grant_alu) begin
        {oCDB_nick, oCDB_dt, oCDB_isBJ, oCDB_j_pc} <= alu_head;
        oCDB_src <= CDB_SRC_ALU;
      end else if (grant_lsb) begin
        {oCDB_nick, oCDB_dt} <= lsb_head;
        oCDB_isBJ <= 1'b0;
        oCDB_j_pc <= '0;
        oCDB_src  <= CDB_SRC_LSB;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a cycle model feeds a scoreboard of
// expected beats, and per-scenario tasks add targeted inline checks.
module tb_cdb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, rdy, iROB_clr;
  logic        iALU_en, iALU_isBJ, iLSB_en;
  logic [3:0]  iALU_nick, iLSB_nick;
  logic [31:0] iALU_dt, iALU_j_pc, iLSB_dt;
  logic        oALU_rdy, oLSB_rdy, oCDB_en, oCDB_isBJ, oCDB_src;
  logic [3:0]  oCDB_nick;
  logic [31:0] oCDB_dt, oCDB_j_pc;

  typedef struct packed {
    logic [3:0]  nick;
    logic [31:0] dt;
    logic        isBJ;
    logic [31:0] j_pc;
    logic        src;
  } beat_t;

  beat_t aq[$];
  beat_t lq[$];
  beat_t exp_q[$];
  beat_t held;
  bit    lg_lsb, alive_m, exp_en, new_beat;
  int    n_cmp, n_fail;

  cdb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .iROB_clr(iROB_clr),
    .iALU_en(iALU_en), .iALU_nick(iALU_nick), .iALU_dt(iALU_dt),
    .iALU_isBJ(iALU_isBJ), .iALU_j_pc(iALU_j_pc), .oALU_rdy(oALU_rdy),
    .iLSB_en(iLSB_en), .iLSB_nick(iLSB_nick), .iLSB_dt(iLSB_dt),
    .oLSB_rdy(oLSB_rdy), .oCDB_en(oCDB_en), .oCDB_nick(oCDB_nick),
    .oCDB_dt(oCDB_dt), .oCDB_isBJ(oCDB_isBJ), .oCDB_j_pc(oCDB_j_pc),
    .oCDB_src(oCDB_src)
  );

  always #5 clk = ~clk;

  function automatic bit m_rdy_a();
    return alive_m && (rdy === 1'b1) && (iROB_clr === 1'b0) && (aq.size() != DEPTH);
  endfunction

  function automatic bit m_rdy_l();
    return alive_m && (rdy === 1'b1) && (iROB_clr === 1'b0) && (lq.size() != DEPTH);
  endfunction

  // Cycle model: grants decided on pre-edge occupancy, pushes land after.
  task automatic model();
    bit ra, rl, ga, gl;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        aq.delete(); lq.delete(); exp_q.delete();
        lg_lsb = 1'b1; alive_m = 1'b0; exp_en = 1'b0; new_beat = 1'b0;
      end else begin
        ra = m_rdy_a();
        rl = m_rdy_l();
        new_beat = 1'b0;
        if (rdy && iROB_clr) begin
          aq.delete(); lq.delete();
          lg_lsb = 1'b1; exp_en = 1'b0;
        end else if (rdy) begin
          ga = (aq.size() != 0) && ((lq.size() == 0) || lg_lsb);
          gl = (lq.size() != 0) && !ga;
          if (aq.size() != 0 && lq.size() != 0) lg_lsb = !ga;
          if (ga) exp_q.push_back(aq.pop_front());
          else if (gl) exp_q.push_back(lq.pop_front());
          new_beat = ga || gl;
          exp_en = ga || gl;
          if (iALU_en && ra) aq.push_back('{iALU_nick, iALU_dt, iALU_isBJ, iALU_j_pc, 1'b0});
          if (iLSB_en && rl) lq.push_back('{iLSB_nick, iLSB_dt, 1'b0, 32'h0, 1'b1});
        end
        alive_m = 1'b1;
      end
    end
  endtask

  task automatic monitor();
    bit er;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) held = '0;
      else begin
        if (new_beat) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sb_underflow: DUT beat %h with no expected entry",
                     {oCDB_nick, oCDB_dt, oCDB_isBJ, oCDB_j_pc, oCDB_src});
          end else held = exp_q.pop_front();
        end
        n_cmp++;
        if (oCDB_en !== exp_en) begin
          n_fail++; $display("FAIL cdb_en @%0t: got %b want %b", $time, oCDB_en, exp_en);
        end
        n_cmp++;
        if ({oCDB_nick, oCDB_dt, oCDB_isBJ, oCDB_j_pc, oCDB_src} !== held) begin
          n_fail++;
          $display("FAIL cdb_fields @%0t: got %h want %h", $time,
                   {oCDB_nick, oCDB_dt, oCDB_isBJ, oCDB_j_pc, oCDB_src}, held);
        end
        er = m_rdy_a();
        n_cmp++;
        if (oALU_rdy !== er) begin
          n_fail++; $display("FAIL alu_rdy @%0t: got %b want %b", $time, oALU_rdy, er);
        end
        er = m_rdy_l();
        n_cmp++;
        if (oLSB_rdy !== er) begin
          n_fail++; $display("FAIL lsb_rdy @%0t: got %b want %b", $time, oLSB_rdy, er);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    iALU_en = 1'b0; iLSB_en = 1'b0; iROB_clr = 1'b0;
  endtask

  task automatic set_alu(input logic [3:0] n, input logic [31:0] d, input logic b,
                         input logic [31:0] j);
    iALU_en = 1'b1; iALU_nick = n; iALU_dt = d; iALU_isBJ = b; iALU_j_pc = j;
  endtask

  task automatic set_lsb(input logic [3:0] n, input logic [31:0] d);
    iLSB_en = 1'b1; iLSB_nick = n; iLSB_dt = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; idle();
    iALU_nick = '0; iALU_dt = '0; iALU_isBJ = 1'b0; iALU_j_pc = '0;
    iLSB_nick = '0; iLSB_dt = '0;
    repeat (3) step();
    n_cmp++;
    if ({oCDB_en, oCDB_nick, oCDB_dt, oCDB_isBJ, oCDB_j_pc, oCDB_src} !== '0) begin
      n_fail++; $display("FAIL reset_cdb: got %h want 0",
                         {oCDB_en, oCDB_nick, oCDB_dt, oCDB_isBJ, oCDB_j_pc, oCDB_src});
    end
    n_cmp++;
    if ({oALU_rdy, oLSB_rdy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_rdy: got %b want 00", {oALU_rdy, oLSB_rdy});
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({oALU_rdy, oLSB_rdy} !== 2'b00) begin
      n_fail++; $display("FAIL release_rdy_pre_edge: got %b want 00", {oALU_rdy, oLSB_rdy});
    end
    step();
    n_cmp++;
    if ({oALU_rdy, oLSB_rdy} !== 2'b11) begin
      n_fail++; $display("FAIL release_rdy_post_edge: got %b want 11", {oALU_rdy, oLSB_rdy});
    end
  endtask

  task automatic test_single();
    set_alu(4'd3, 32'h1234, 1'b1, 32'h80);
    step();
    idle();
    n_cmp++;
    if (oCDB_en !== 1'b0) begin
      n_fail++; $display("FAIL single_latency: got en=%b want 0", oCDB_en);
    end
    step();
    n_cmp++;
    if ({oCDB_en, oCDB_nick, oCDB_dt, oCDB_isBJ, oCDB_j_pc, oCDB_src} !==
        {1'b1, 4'd3, 32'h1234, 1'b1, 32'h80, 1'b0}) begin
      n_fail++; $display("FAIL single_beat: got %h want %h",
                         {oCDB_en, oCDB_nick, oCDB_dt, oCDB_isBJ, oCDB_j_pc, oCDB_src},
                         {1'b1, 4'd3, 32'h1234, 1'b1, 32'h80, 1'b0});
    end
    step();
    n_cmp++;
    if (oCDB_en !== 1'b0) begin
      n_fail++; $display("FAIL single_one_cycle: got en=%b want 0", oCDB_en);
    end
  endtask

  task automatic test_tie();
    bit exp_alt [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int k = 0;
    set_alu(4'd1, 32'hA1, 1'b0, 32'h0);
    set_lsb(4'd2, 32'hB2);
    step();
    idle();
    step();
    n_cmp++;
    if ({oCDB_en, oCDB_src, oCDB_nick} !== {1'b1, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL tie_first: got en/src/nick %b/%b/%0d want 1/0/1",
                         oCDB_en, oCDB_src, oCDB_nick);
    end
    step();
    n_cmp++;
    if ({oCDB_en, oCDB_src, oCDB_nick, oCDB_isBJ, oCDB_j_pc} !== {1'b1, 1'b1, 4'd2, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL tie_second: got en/src/nick %b/%b/%0d want 1/1/2",
                         oCDB_en, oCDB_src, oCDB_nick);
    end
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c < 4) begin
        if (m_rdy_a()) set_alu(4'(8 + c), 32'h100 + c, c[0], 32'h200 + 4 * c);
        if (m_rdy_l()) set_lsb(4'(12 + c), 32'h300 + c);
      end
      step();
      if (oCDB_en === 1'b1) begin
        if (k < 6) begin
          n_cmp++;
          if (oCDB_src !== exp_alt[k]) begin
            n_fail++; $display("FAIL alternate[%0d]: got src %b want %b", k, oCDB_src, exp_alt[k]);
          end
        end
        k++;
      end
    end
    n_cmp++;
    if (k != 6) begin
      n_fail++; $display("FAIL alternate_count: got %0d beats want 6", k);
    end
  endtask

  task automatic test_full();
    int  a_cnt = 0;
    int  l_cnt = 0;
    bit  saw_full = 1'b0;
    for (int c = 0; c < 20; c++) begin
      idle();
      if (aq.size() == DEPTH) begin
        saw_full = 1'b1;
        n_cmp++;
        if (oALU_rdy !== 1'b0) begin
          n_fail++; $display("FAIL full_rdy: got %b want 0", oALU_rdy);
        end
      end
      if (a_cnt < 4 && m_rdy_a()) begin
        set_alu(4'(c), 32'hA000 + c, c[0], 32'h400 + 4 * c);
        a_cnt++;
      end
      if (l_cnt < 4 && m_rdy_l()) begin
        set_lsb(4'(15 - c), 32'hB000 + c);
        l_cnt++;
      end
      step();
      if (a_cnt == 4 && l_cnt == 4) break;
    end
    idle();
    n_cmp++;
    if (a_cnt != 4 || l_cnt != 4) begin
      n_fail++; $display("FAIL full_timeout: pushed alu %0d lsb %0d want 4/4", a_cnt, l_cnt);
    end
    n_cmp++;
    if (!saw_full) begin
      n_fail++; $display("FAIL full_reached: got never-full want count=%0d", DEPTH);
    end
    repeat (6) step();
  endtask

  task automatic test_flush();
    for (int c = 0; c < 2; c++) begin
      set_alu(4'(4 + c), 32'hC000 + c, 1'b1, 32'h600 + c);
      set_lsb(4'(6 + c), 32'hD000 + c);
      step();
    end
    idle();
    iROB_clr = 1'b1;
    #1;
    n_cmp++;
    if ({oALU_rdy, oLSB_rdy} !== 2'b00) begin
      n_fail++; $display("FAIL flush_rdy_during: got %b want 00", {oALU_rdy, oLSB_rdy});
    end
    step();
    idle();
    #1;
    n_cmp++;
    if ({oCDB_en, oALU_rdy, oLSB_rdy} !== 3'b011) begin
      n_fail++; $display("FAIL flush_after: got en/rdy %b want 011", {oCDB_en, oALU_rdy, oLSB_rdy});
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (oCDB_en !== 1'b0) begin
        n_fail++; $display("FAIL flush_stale[%0d]: got en=%b nick=%0d want en=0", c, oCDB_en, oCDB_nick);
      end
    end
  endtask

  task automatic test_pause();
    int beats = 0;
    for (int c = 0; c < 2; c++) begin
      set_alu(4'(9 + c), 32'hE000 + c, 1'b0, 32'h700 + c);
      set_lsb(4'(11 + c), 32'hF000 + c);
      step();
    end
    idle();
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      iROB_clr = (c == 1);
      #1;
      n_cmp++;
      if ({oCDB_en, oALU_rdy, oLSB_rdy} !== 3'b100) begin
        n_fail++; $display("FAIL pause[%0d]: got en/rdy %b want 100", c, {oCDB_en, oALU_rdy, oLSB_rdy});
      end
      step();
    end
    idle();
    rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (oCDB_en === 1'b1) beats++;
    end
    n_cmp++;
    if (beats != 3) begin
      n_fail++; $display("FAIL pause_resume: got %0d beats want 3", beats);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      set_alu(4'(1 + c), 32'h5000 + c, 1'b1, 32'h900 + c);
      set_lsb(4'(3 + c), 32'h6000 + c);
      if (c == 0) step();
    end
    @(posedge clk);
    #3;
    idle();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({oCDB_en, oCDB_nick, oCDB_dt, oCDB_isBJ, oCDB_j_pc, oCDB_src, oALU_rdy, oLSB_rdy} !== '0) begin
      n_fail++; $display("FAIL midreset_clear: got %h want 0",
                         {oCDB_en, oCDB_nick, oCDB_dt, oCDB_isBJ, oCDB_j_pc, oCDB_src, oALU_rdy, oLSB_rdy});
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    set_alu(4'd5, 32'h55, 1'b0, 32'h0);
    set_lsb(4'd6, 32'h66);
    step();
    idle();
    step();
    n_cmp++;
    if ({oCDB_en, oCDB_src, oCDB_nick} !== {1'b1, 1'b0, 4'd5}) begin
      n_fail++; $display("FAIL midreset_tie_first: got en/src/nick %b/%b/%0d want 1/0/5",
                         oCDB_en, oCDB_src, oCDB_nick);
    end
    step();
    n_cmp++;
    if ({oCDB_en, oCDB_src, oCDB_nick} !== {1'b1, 1'b1, 4'd6}) begin
      n_fail++; $display("FAIL midreset_tie_second: got en/src/nick %b/%b/%0d want 1/1/6",
                         oCDB_en, oCDB_src, oCDB_nick);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; held = '0;
    lg_lsb = 1'b1; alive_m = 1'b0; exp_en = 1'b0; new_beat = 1'b0;
    rst_n = 1'b0; rdy = 1'b1;
    iALU_en = 1'b0; iLSB_en = 1'b0; iROB_clr = 1'b0;
    fork
      model();
      monitor();
    join_none
    test_reset();
    test_single();
    test_tie();
    test_full();
    test_flush();
    test_pause();
    test_reset_mid();
    repeat (3) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
